// File: rtl/kernel_launcher.sv
`default_nettype none
// =============================================================================
// kernel_launcher : queues host kernel descriptors, runs each on the GPU. Rev 1.0
// =============================================================================
module kernel_launcher #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CONFIG_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               launch_valid,
    input  logic [CONFIG_WIDTH-1:0]            launch_config,
    output logic                               launch_ready,
    output logic [7:0]                         launch_id,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic                               busy,
    output logic                               gpu_reset,
    output logic                               gpu_execution_start,
    output logic [CONFIG_WIDTH-1:0]            gpu_kernel_config,
    input  logic                               gpu_execution_done,
    output logic                               done_valid,
    output logic [7:0]                         done_id,
    output logic [31:0]                        done_cycles,
    output logic                               done_timeout
);

    localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int RST_W   = $clog2(RESET_CYCLES + 1);
    localparam int ENTRY_W = CONFIG_WIDTH + 8;

    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [RST_W-1:0] C_RST_LOAD   = RST_W'(RESET_CYCLES);
    localparam logic [31:0]      C_TIMEOUT    = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_GPU = 3'd1,
        S_START     = 3'd2,
        S_RUN       = 3'd3,
        S_COMPLETE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [ENTRY_W-1:0]       mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [7:0]               next_id_q, next_id_d;
    logic [CONFIG_WIDTH-1:0]  cfg_q, cfg_d;
    logic [7:0]               id_q, id_d;
    logic [RST_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [31:0]              cyc_cnt_q, cyc_cnt_d;
    logic [7:0]               done_id_q, done_id_d;
    logic [31:0]              done_cycles_q, done_cycles_d;
    logic                     done_timeout_q, done_timeout_d;

    logic                     push;
    logic                     pop;
    logic [ENTRY_W-1:0]       head;
    logic [31:0]              cyc_inc;

    // Full is the only back-pressure: a same-cycle pop never frees a slot early.
    assign launch_ready = (count_q != C_FULL_COUNT);
    assign push         = launch_valid && launch_ready;
    assign head         = mem_q[rd_ptr_q];
    assign cyc_inc      = (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : cyc_cnt_q + 32'd1;

    assign launch_id           = next_id_q;
    assign queue_count         = count_q;
    assign busy                = (state_q != S_IDLE);
    assign gpu_reset           = (state_q != S_START) && (state_q != S_RUN);
    assign gpu_execution_start = (state_q == S_START) || (state_q == S_RUN);
    assign gpu_kernel_config   = cfg_q;
    assign done_valid          = (state_q == S_COMPLETE);
    assign done_id             = done_id_q;
    assign done_cycles         = done_cycles_q;
    assign done_timeout        = done_timeout_q;

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        cfg_d          = cfg_q;
        id_d           = id_q;
        rst_cnt_d      = rst_cnt_q;
        cyc_cnt_d      = cyc_cnt_q;
        done_id_d      = done_id_q;
        done_cycles_d  = done_cycles_q;
        done_timeout_d = done_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    cfg_d     = head[ENTRY_W-1:8];
                    id_d      = head[7:0];
                    rst_cnt_d = C_RST_LOAD;
                    state_d   = S_RESET_GPU;
                end
            end
            S_RESET_GPU: begin
                rst_cnt_d = rst_cnt_q - RST_W'(1);
                if (rst_cnt_q <= RST_W'(1)) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cyc_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                cyc_cnt_d = cyc_inc;
                // done has priority over a timeout landing in the same cycle
                if (gpu_execution_done) begin
                    done_id_d      = id_q;
                    done_cycles_d  = cyc_inc;
                    done_timeout_d = 1'b0;
                    state_d        = S_COMPLETE;
                end else if ((C_TIMEOUT != 32'd0) && (cyc_inc == C_TIMEOUT)) begin
                    done_id_d      = id_q;
                    done_cycles_d  = cyc_inc;
                    done_timeout_d = 1'b1;
                    state_d        = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        next_id_d = push ? next_id_q + 8'd1 : next_id_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {launch_config, next_id_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            next_id_q      <= '0;
            cfg_q          <= '0;
            id_q           <= '0;
            rst_cnt_q      <= '0;
            cyc_cnt_q      <= '0;
            done_id_q      <= '0;
            done_cycles_q  <= '0;
            done_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            next_id_q      <= next_id_d;
            cfg_q          <= cfg_d;
            id_q           <= id_d;
            rst_cnt_q      <= rst_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            done_id_q      <= done_id_d;
            done_cycles_q  <= done_cycles_d;
            done_timeout_q <= done_timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_launcher.sv
`default_nettype none
// =============================================================================
// tb_kernel_launcher : directed bench for kernel_launcher with a small GPU model. Rev 1.0
// =============================================================================
module tb_kernel_launcher;

    localparam int QD = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          launch_valid;
    logic [CW-1:0] launch_config;
    logic          launch_ready;
    logic [7:0]    launch_id;
    logic [2:0]    queue_count;
    logic          busy;
    logic          gpu_reset;
    logic          gpu_execution_start;
    logic [CW-1:0] gpu_kernel_config;
    logic          gpu_execution_done;
    logic          done_valid;
    logic [7:0]    done_id;
    logic [31:0]   done_cycles;
    logic          done_timeout;

    int n_cmp = 0;
    int n_err = 0;

    // GPU model: done rises in RUN cycle done_at (0 = never), or always when force_done
    int          done_at    = 0;
    logic        force_done = 1'b0;
    logic [31:0] gpu_cnt    = 32'd0;

    logic [7:0]  dq_id[$];
    logic [31:0] dq_cyc[$];
    logic        dq_to[$];
    logic [2:0]  last_qc;

    kernel_launcher #(
        .QUEUE_DEPTH   (QD),
        .RESET_CYCLES  (2),
        .TIMEOUT_CYCLES(20),
        .CONFIG_WIDTH  (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .launch_valid       (launch_valid),
        .launch_config      (launch_config),
        .launch_ready       (launch_ready),
        .launch_id          (launch_id),
        .queue_count        (queue_count),
        .busy               (busy),
        .gpu_reset          (gpu_reset),
        .gpu_execution_start(gpu_execution_start),
        .gpu_kernel_config  (gpu_kernel_config),
        .gpu_execution_done (gpu_execution_done),
        .done_valid         (done_valid),
        .done_id            (done_id),
        .done_cycles        (done_cycles),
        .done_timeout       (done_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gpu_cnt <= gpu_reset ? 32'd0 : gpu_cnt + 32'd1;

    assign gpu_execution_done = force_done ||
        ((done_at != 0) && !gpu_reset && (gpu_cnt == 32'(done_at)));

    always @(negedge clk) begin
        if (done_valid === 1'b1) begin
            dq_id.push_back(done_id);
            dq_cyc.push_back(done_cycles);
            dq_to.push_back(done_timeout);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        launch_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at #1 after the accepting edge; waits counts stalled cycles.
    task automatic push(input logic [CW-1:0] cfg, output logic [7:0] id, output int waits);
        @(negedge clk);
        launch_valid  = 1'b1;
        launch_config = cfg;
        waits         = 0;
        while (!launch_ready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (!launch_ready) check("push_stalled", 64'(launch_ready), 64'd1);
        id      = launch_id;
        last_qc = queue_count;
        @(posedge clk);
        #1;
        launch_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int guard = 0;
        while (dq_id.size() < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (dq_id.size() < n) check("wait_done_timeout", 64'(dq_id.size()), 64'(n));
    endtask

    task automatic wait_run();
        int guard = 0;
        @(negedge clk);
        while (!(gpu_execution_start && !gpu_reset) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("wait_run_timeout", 64'(gpu_execution_start), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  id;
        int          w;
        int          base;
        int          wsum;
        int          errs;
        int          first_start;
        int          dv_cycle;
        logic [16:0] rst_seen;
        logic [16:0] st_seen;
        logic [16:0] dv_seen;
        logic [CW-1:0] cfg_seen;

        reset         = 1'b1;
        launch_valid  = 1'b0;
        launch_config = '0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_launch_ready", 64'(launch_ready), 64'd1);
        check("rst_queue_count",  64'(queue_count), 64'd0);
        check("rst_busy",         64'(busy), 64'd0);
        check("rst_gpu_reset",    64'(gpu_reset), 64'd1);
        check("rst_exec_start",   64'(gpu_execution_start), 64'd0);
        check("rst_gpu_config",   64'(gpu_kernel_config), 64'd0);
        check("rst_done_fields",  {done_valid, done_id, done_cycles, done_timeout}, 64'd0);
        check("rst_launch_id",    64'(launch_id), 64'd0);
        reset = 1'b0;

        // single launch: done in the 10th RUN cycle
        done_at  = 10;
        base     = dq_id.size();
        rst_seen = '0; st_seen = '0; dv_seen = '0; cfg_seen = '0;
        push(32'hA5A5_0001, id, w);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            rst_seen[k] = gpu_reset;
            st_seen[k]  = gpu_execution_start;
            dv_seen[k]  = done_valid;
            if (k == 8) cfg_seen = gpu_kernel_config;
        end
        first_start = 0;
        dv_cycle    = 0;
        for (int k = 16; k >= 1; k--) begin
            if (st_seen[k]) first_start = k;
            if (dv_seen[k]) dv_cycle = k;
        end
        check("single_id",          64'(id), 64'd0);
        check("single_first_start", 64'(first_start), 64'd4);
        check("single_reset_c1_4",  64'(rst_seen[4:1]), 64'b0111);
        check("single_run_config",  64'(cfg_seen), 64'hA5A5_0001);
        check("single_done_cycle",  64'(dv_cycle), 64'd15);
        check("single_reset_c15",   64'(rst_seen[15]), 64'd1);
        wait_done(base + 1);
        check("single_done_id",     64'(dq_id[base]), 64'd0);
        check("single_done_cycles", 64'(dq_cyc[base]), 64'd10);
        check("single_done_to",     64'(dq_to[base]), 64'd0);

        // queue fill while kernel 0 runs
        do_reset();
        done_at = 5;
        base    = dq_id.size();
        push(32'h0000_0100, id, w);
        wait_run();
        wsum = 0;
        for (int i = 1; i <= 4; i++) begin
            push(32'h0000_0100 + 32'(i), id, w);
            wsum += w;
            if (i == 4) check("fill_id4", 64'(id), 64'd4);
        end
        check("fill_no_stall", 64'(wsum), 64'd0);
        @(negedge clk);
        check("fill_ready_low", 64'(launch_ready), 64'd0);
        check("fill_count4",    64'(queue_count), 64'd4);
        push(32'h0000_0105, id, w);
        check("fill_5th_stalled",  64'(w > 0), 64'd1);
        check("fill_5th_after_pop", 64'(last_qc), 64'd3);
        check("fill_5th_id",       64'(id), 64'd5);
        wait_done(base + 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_order_%0d", i), 64'(dq_id[base + i]), 64'(i));
        end

        // timeout, then the next kernel runs normally
        do_reset();
        done_at = 0;
        base    = dq_id.size();
        push(32'h0000_0200, id, w);
        push(32'h0000_0201, id, w);
        wait_done(base + 1);
        done_at = 3;
        check("to_flag",   64'(dq_to[base]), 64'd1);
        check("to_cycles", 64'(dq_cyc[base]), 64'd20);
        wait_done(base + 2);
        check("to_next_id",     64'(dq_id[base + 1]), 64'd1);
        check("to_next_cycles", 64'(dq_cyc[base + 1]), 64'd3);
        check("to_next_flag",   64'(dq_to[base + 1]), 64'd0);

        // done held high early is ignored until RUN
        do_reset();
        force_done = 1'b1;
        base       = dq_id.size();
        push(32'h0000_0300, id, w);
        wait_done(base + 1);
        force_done = 1'b0;
        check("early_cycles", 64'(dq_cyc[base]), 64'd1);
        check("early_flag",   64'(dq_to[base]), 64'd0);

        // reset in the middle of RUN drops everything
        do_reset();
        done_at = 0;
        for (int i = 0; i < 3; i++) push(32'h0000_0400 + 32'(i), id, w);
        wait_run();
        repeat (3) @(negedge clk);
        check("mid_queued", 64'(queue_count), 64'd2);
        base = dq_id.size();
        reset = 1'b1;
        @(negedge clk);
        check("mid_gpu_reset", 64'(gpu_reset), 64'd1);
        check("mid_count",     64'(queue_count), 64'd0);
        check("mid_next_id",   64'(launch_id), 64'd0);
        check("mid_busy",      64'(busy), 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_no_done", 64'(dq_id.size()), 64'(base));

        // id wrap over 257 launches
        do_reset();
        done_at = 1;
        base    = dq_id.size();
        for (int i = 1; i <= 257; i++) begin
            push(32'(i), id, w);
            if (i == 256) check("wrap_id_256th", 64'(id), 64'd255);
            if (i == 257) check("wrap_id_257th", 64'(id), 64'd0);
        end
        wait_done(base + 257);
        errs = 0;
        for (int i = 0; i < 257 && base + i < dq_id.size(); i++) begin
            if (dq_id[base + i] !== 8'(i)) errs++;
        end
        check("wrap_order_errs", 64'(errs), 64'd0);
        if (dq_id.size() >= base + 257) check("wrap_last_id", 64'(dq_id[base + 256]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
